// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction fetch stage. Issues sequential word reads to
//               instruction memory under a FIFO credit limit, buffers the
//               returned words with their PC and presents the head entry to
//               decode over a valid/ready handshake. A flush redirects the PC
//               and discards all buffered and in-flight words.
//               Optional performance counters: define FETCH_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_fetch_cnt,
  output logic [15:0] perf_flush_cnt,
`endif
  output logic [5:0]  opCode,
  output logic [5:0]  funct
);

  localparam int unsigned        c_PTR_W   = $clog2(DEPTH);
  localparam int unsigned        c_CNT_W   = c_PTR_W + 1;
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = 1;
  localparam logic [c_CNT_W:0]   c_DEPTH_S = DEPTH[c_CNT_W:0];

  // Architectural state
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        rsp_pc_q, rsp_pc_d;
  logic [c_CNT_W-1:0] count_q, count_d;
  logic [c_CNT_W-1:0] outst_q, outst_d;
  logic [c_CNT_W-1:0] drop_q, drop_d;
  logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  // Entry storage; contents only matter while the entry is counted as valid
  logic [31:0] mem_instr_q [DEPTH];
  logic [31:0] mem_pc_q    [DEPTH];

  logic [c_CNT_W:0] w_credit_sum;
  logic             w_grant;
  logic             w_rsp;
  logic             w_rsp_drop;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_flush_target;
  logic             w_unused_flush_lsbs;

  // Credit counts both buffered words and words still in flight, so every
  // granted read is guaranteed a FIFO slot when it returns.
  assign w_credit_sum = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req     = !reset && !flush && (w_credit_sum < c_DEPTH_S);
  assign imem_addr    = pc_q;
  assign w_grant      = imem_req && imem_gnt;

  // Responses retire pending drops first (they belong to older, flushed reads);
  // an rvalid with nothing pending is ignored.
  assign w_rsp_drop = imem_rvalid && (drop_q != '0);
  assign w_push     = imem_rvalid && (drop_q == '0) && (outst_q != '0);
  assign w_rsp      = w_rsp_drop || w_push;

  assign id_valid = (count_q != '0);
  assign w_pop    = id_valid && id_ready;

  assign w_flush_target      = {flush_pc[31:2], 2'b00};
  assign w_unused_flush_lsbs = ^flush_pc[1:0];

  // Next-state computation for PC, pointers and counters
  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    count_d  = count_q;
    outst_d  = outst_q;
    drop_d   = drop_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      // Everything in flight becomes a drop; a response landing this same
      // cycle is itself discarded and so already accounted for.
      pc_d     = w_flush_target;
      rsp_pc_d = w_flush_target;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      outst_d  = '0;
      drop_d   = drop_q + outst_q - {{c_PTR_W{1'b0}}, w_rsp};
    end else begin
      if (w_grant) begin
        pc_d = pc_q + 32'd4;
      end
      if (w_push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + c_PTR_ONE;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + c_PTR_ONE;
      end
      if (w_rsp_drop) begin
        drop_d = drop_q - c_CNT_ONE;
      end
      count_d = count_q + {{c_PTR_W{1'b0}}, w_push} - {{c_PTR_W{1'b0}}, w_pop};
      outst_d = outst_q + {{c_PTR_W{1'b0}}, w_grant} - {{c_PTR_W{1'b0}}, w_push};
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      count_q  <= '0;
      outst_q  <= '0;
      drop_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Capture accepted response words together with their PC
  always_ff @(posedge clk) begin
    if (!reset && !flush && w_push) begin
      mem_instr_q[wr_ptr_q] <= imem_rdata;
      mem_pc_q[wr_ptr_q]    <= rsp_pc_q;
    end
  end

  // An empty queue presents all-zero instruction (a NOP to decode)
  assign id_instr = id_valid ? mem_instr_q[rd_ptr_q] : 32'h0;
  assign id_pc    = id_valid ? mem_pc_q[rd_ptr_q]    : 32'h0;
  assign opCode   = id_instr[31:26];
  assign funct    = id_instr[5:0];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_fetch_q;
  logic [15:0] perf_flush_q;

  // Saturating event counters: stalls, accepted pops, flush cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (id_valid && !id_ready && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (w_pop && !flush && (perf_fetch_q != '1)) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (flush && (perf_flush_q != '1)) begin
        perf_flush_q <= perf_flush_q + 16'd1;
      end
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

  // A response with nothing in flight and nothing to drop is a memory protocol error
  a_no_orphan_rsp : assert property (@(posedge clk) disable iff (reset)
    !(imem_rvalid && (outst_q == '0) && (drop_q == '0)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Directed self-checking bench for fetch_queue (DEPTH=4,
//               RESET_PC=0x100) with a fixed-latency in-order memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h100;

  logic        clk = 1'b0;
  logic        reset, imem_req, imem_gnt, imem_rvalid, flush, id_valid, id_ready;
  logic [31:0] imem_addr, imem_rdata, flush_pc, id_instr, id_pc;
  logic [5:0]  opCode, funct;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_fetch_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .flush(flush), .flush_pc(flush_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
`ifdef FETCH_PERF_CNT_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_fetch_cnt(perf_fetch_cnt),
    .perf_flush_cnt(perf_flush_cnt),
`endif
    .opCode(opCode), .funct(funct)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        rq[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          lat      = 1;
  int          grants   = 0;
  logic        g_now, rsp_now;
  logic [31:0] g_addr;

  // Memory contents: opCode = addr[7:2]^0x2A, funct = addr[7:2]
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[7:2] ^ 6'h2A, 20'hABCDE, a[7:2]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present this cycle's memory response, then let the DUT settle
  task automatic prep();
    if (!reset && rq.size() > 0 && rq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = data_of(rq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    #1;
  endtask

  // Record grant/response of this cycle, cross the clock edge
  task automatic adv();
    g_now   = imem_req && imem_gnt;
    g_addr  = imem_addr;
    rsp_now = imem_rvalid;
    @(posedge clk);
    #1;
    if (reset) begin
      rq.delete();
    end else begin
      if (rsp_now) void'(rq.pop_front());
      if (g_now) begin
        rq.push_back('{g_addr, cyc + lat});
        grants++;
      end
    end
    cyc++;
  endtask

  task automatic step();
    prep();
    adv();
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; flush_pc = 32'h0; imem_gnt = 1'b1; id_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; flush_pc = 32'h0; imem_gnt = 1'b1; id_ready = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = 32'h0; lat = 1;

    // Reset state
    step();
    step();
    prep();
    check_eq("rst_valid", id_valid, 0);
    check_eq("rst_instr", id_instr, 0);
    check_eq("rst_pc", id_pc, 0);
    check_eq("rst_opcode", opCode, 0);
    check_eq("rst_funct", funct, 0);
    check_eq("rst_req", imem_req, 0);
    adv();
    reset = 1'b0;
    cyc   = 0;

    // Sequential streaming, latency 1
    for (int k = 0; k < 8; k++) begin
      prep();
      check_eq("t1_req", imem_req, 1);
      check_eq("t1_addr", imem_addr, 32'h100 + 32'(4 * k));
      if (k == 1) check_eq("t1_valid_late", id_valid, 0);
      if (k >= 2) begin
        check_eq("t1_valid", id_valid, 1);
        check_eq("t1_idpc", id_pc, 32'h100 + 32'(4 * (k - 2)));
      end
      if (k == 3) begin
        check_eq("t1_instr", id_instr, 32'hAEAF3781);
        check_eq("t1_opcode", opCode, 6'h2B);
        check_eq("t1_funct", funct, 6'h01);
      end
      adv();
    end

    // Back-pressure: credit limit, then drain in order
    do_reset();
    id_ready = 1'b0;
    grants   = 0;
    for (int k = 0; k < 10; k++) step();
    check_eq("t2_grants", grants, DEPTH);
    prep();
    check_eq("t2_req_full", imem_req, 0);
    check_eq("t2_hold_valid", id_valid, 1);
    check_eq("t2_hold_pc", id_pc, 32'h100);
    adv();
    id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      prep();
      check_eq("t2_pop_pc", id_pc, 32'h100 + 32'(4 * i));
      if (i == 1) begin
        check_eq("t2_resume_req", imem_req, 1);
        check_eq("t2_resume_addr", imem_addr, 32'h110);
      end
      adv();
    end

    // Flush with three reads in flight, unaligned target
    do_reset();
    lat = 4;
    for (int k = 0; k < 3; k++) step();
    flush = 1'b1; flush_pc = 32'h203;
    prep();
    check_eq("t3_req_in_flush", imem_req, 0);
    adv();
    flush = 1'b0;
    prep();
    check_eq("t3_req", imem_req, 1);
    check_eq("t3_addr", imem_addr, 32'h200);
    check_eq("t3_empty", id_valid, 0);
    adv();
    for (int k = 5; k <= 8; k++) begin
      prep();
      check_eq("t3_drop_empty", id_valid, 0);
      adv();
    end
    prep();
    check_eq("t3_valid", id_valid, 1);
    check_eq("t3_first_pc", id_pc, 32'h200);
    adv();
    prep();
    check_eq("t3_second_pc", id_pc, 32'h204);
    adv();

    // Flush coinciding with a response and a pop
    do_reset();
    lat = 2;
    for (int k = 0; k < 3; k++) step();
    flush = 1'b1; flush_pc = 32'h300;
    prep();
    check_eq("t4_valid_at_flush", id_valid, 1);
    adv();
    flush = 1'b0;
    prep();
    check_eq("t4_empty", id_valid, 0);
    check_eq("t4_addr", imem_addr, 32'h300);
    adv();
    for (int k = 5; k <= 6; k++) begin
      prep();
      check_eq("t4_still_empty", id_valid, 0);
      adv();
    end
    prep();
    check_eq("t4_valid", id_valid, 1);
    check_eq("t4_first_pc", id_pc, 32'h300);
    adv();
    prep();
    check_eq("t4_second_pc", id_pc, 32'h304);
    adv();

    // PC wrap at 2^32
    do_reset();
    lat = 1;
    for (int k = 0; k < 4; k++) step();
    flush = 1'b1; flush_pc = 32'hFFFF_FFFE;
    step();
    flush = 1'b0;
    prep();
    check_eq("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    adv();
    prep();
    check_eq("t5_addr_wrap", imem_addr, 32'h0);
    adv();
    prep();
    check_eq("t5_idpc_top", id_pc, 32'hFFFF_FFFC);
    adv();
    prep();
    check_eq("t5_valid_wrap", id_valid, 1);
    check_eq("t5_idpc_wrap", id_pc, 32'h0);
    check_eq("t5_opcode_wrap", opCode, 6'h2A);
    adv();

`ifdef FETCH_PERF_CNT_EN
    // Performance counters: 5 stalls, 3 pops, 1 flush, then reset
    do_reset();
    lat = 1;
    id_ready = 1'b0;
    for (int k = 0; k < 7; k++) step();
    id_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    flush = 1'b1; flush_pc = 32'h400;
    step();
    flush = 1'b0; id_ready = 1'b0;
    prep();
    check_eq("t6_stall", perf_stall_cnt, 5);
    check_eq("t6_fetch", perf_fetch_cnt, 3);
    check_eq("t6_flush", perf_flush_cnt, 1);
    adv();
    reset = 1'b1;
    step();
    prep();
    check_eq("t6_stall_rst", perf_stall_cnt, 0);
    check_eq("t6_fetch_rst", perf_fetch_cnt, 0);
    check_eq("t6_flush_rst", perf_flush_cnt, 0);
    adv();
    reset = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
